rt_operand_loader: RTL
======================

Name: rt_operand_loader

Overview:
- Downstream consumer of the secondary-input stage (r, t, n0' precompute for Montgomery exponentiation).
- Captures the MSW-first stream of 64-bit r and t words into two NUM_WORDS-deep word stores, LSW at address 0.
- Latches n0' and presents all three operands to the Montgomery multiplier through a registered, word-addressed read port.
- Flags short and over-long transfers.

Parameters:
- DATA_WIDTH, 64, word width of r, t, n0'
- ADDR_WIDTH, 4, read address width
- NUM_WORDS, 16, words per operand (NUM_WORDS*DATA_WIDTH = 1024-bit operand); must be <= 2**ADDR_WIDTH

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- load_start  in  1  one-cycle pulse; begins a new load and invalidates current contents
- word_valid  in  1  r_word/t_word carry a valid word this cycle
- r_word  in  DATA_WIDTH  r word, MSW first
- t_word  in  DATA_WIDTH  t word, MSW first
- n0p_in  in  DATA_WIDTH  n0' value, stable when load_done is high
- load_done  in  1  one-cycle pulse; upstream transfer complete
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  word address, 0 = LSW
- r_rd_data  out  DATA_WIDTH  registered r word
- t_rd_data  out  DATA_WIDTH  registered t word
- rd_valid  out  1  rd data valid this cycle
- n0p_out  out  DATA_WIDTH  latched n0'
- ready  out  1  operands complete and readable
- busy  out  1  load in progress
- word_count  out  ADDR_WIDTH+1  words accepted in current/last load
- overflow  out  1  sticky: words beyond NUM_WORDS were discarded
- underflow  out  1  sticky: load_done arrived with fewer than NUM_WORDS words

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs 0. Internal write pointer = NUM_WORDS-1. Store contents don't-care. Reset overrides every other input, including mid-load.
- States: IDLE, LOAD, READY. busy=1 only in LOAD. ready=1 only in READY.
- load_start:
  - Accepted in any state; highest priority.
  - Next state LOAD; wr_ptr=NUM_WORDS-1; word_count, overflow, underflow, ready cleared.
  - word_valid/load_done in the same cycle are ignored.
- LOAD, word_valid with word_count<NUM_WORDS:
  - Write r_word to r_mem[wr_ptr] and t_word to t_mem[wr_ptr].
  - wr_ptr decrements; word_count increments.
  - First word lands at NUM_WORDS-1, NUM_WORDS-th word at 0.
- LOAD, word_valid with word_count==NUM_WORDS: word discarded, overflow<=1; word_count saturates at NUM_WORDS.
- LOAD, load_done:
  - n0p_out<=n0p_in.
  - Evaluated on word count including any word_valid in the same cycle (that word is accepted first).
  - Count==NUM_WORDS: -> READY, ready=1 from next cycle.
  - Count<NUM_WORDS: underflow<=1, -> IDLE, ready stays 0.
- load_done outside LOAD: ignored, n0p_out unchanged. word_valid outside LOAD: ignored.
- READY, rd_en:
  - Next cycle: r_rd_data=r_mem[rd_addr], t_rd_data=t_mem[rd_addr], rd_valid=1 for one cycle. Latency 1; back-to-back reads every cycle.
  - rd_addr>=NUM_WORDS returns 0 on both data outputs with rd_valid=1.
- rd_en in IDLE/LOAD: ignored; rd_valid=0, data outputs hold last value.
- READY persists until load_start or reset. n0p_out, overflow, underflow, word_count hold until next load_start or reset.

Test Plan:
- Reset: drive random inputs with rst_n=0 for 3 cycles -> all outputs 0, busy=0, ready=0.
- Nominal load: load_start; 16 cycles word_valid with r=0x1000+k, t=0x2000+k (k=0..15); load_done with n0p_in=0xDEADBEEF_CAFEF00D -> ready=1 next cycle, word_count=16, n0p_out latched. Read addr 0 -> r=0x100F, t=0x200F one cycle later. Addr 15 -> 0x1000/0x2000.
- Overflow: 17 words, 17th = 0xFFFF..FF -> overflow=1, ready=1 after load_done, addr 0 still 0x100F, word_count=16.
- Underflow: 10 words then load_done -> underflow=1, ready=0, busy=0, word_count=10. rd_en -> rd_valid stays 0.
- Simultaneous events:
  - 16th word_valid coincident with load_done -> word stored at addr 0, ready=1, no underflow.
  - load_start coincident with word_valid during READY -> word ignored, word_count=0, busy=1, ready=0.
- Reset mid-load: rst_n=0 after 5 words -> IDLE, word_count=0. New full load afterwards completes normally with correct contents.

Source files
------------

// File: rtl/rt_operand_loader_if.sv
// rt_operand_loader_if: load stream, read port and status bundle for rt_operand_loader
//   master : upstream stage / multiplier side (drives load stream and read requests)
//   slave  : rt_operand_loader (drives read data, n0' and status)
interface rt_operand_loader_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 4
);
   logic                  i_load_start;
   logic                  i_word_valid;
   logic [DATA_WIDTH-1:0] i_r_word;
   logic [DATA_WIDTH-1:0] i_t_word;
   logic [DATA_WIDTH-1:0] i_n0p_in;
   logic                  i_load_done;
   logic                  i_rd_en;
   logic [ADDR_WIDTH-1:0] i_rd_addr;
   logic [DATA_WIDTH-1:0] o_r_rd_data;
   logic [DATA_WIDTH-1:0] o_t_rd_data;
   logic                  o_rd_valid;
   logic [DATA_WIDTH-1:0] o_n0p_out;
   logic                  o_ready;
   logic                  o_busy;
   logic [ADDR_WIDTH:0]   o_word_count;
   logic                  o_overflow;
   logic                  o_underflow;
   modport master (
      output i_load_start, i_word_valid, i_r_word, i_t_word, i_n0p_in, i_load_done, i_rd_en, i_rd_addr,
      input  o_r_rd_data, o_t_rd_data, o_rd_valid, o_n0p_out, o_ready, o_busy, o_word_count, o_overflow, o_underflow
   );
   modport slave (
      input  i_load_start, i_word_valid, i_r_word, i_t_word, i_n0p_in, i_load_done, i_rd_en, i_rd_addr,
      output o_r_rd_data, o_t_rd_data, o_rd_valid, o_n0p_out, o_ready, o_busy, o_word_count, o_overflow, o_underflow
   );
endinterface

// File: rtl/rt_operand_loader.sv
// rt_operand_loader: captures MSW-first r/t word streams and n0', serves them LSW-addressed to the Montgomery multiplier
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : slave side of rt_operand_loader_if (load stream in, registered read port and status out)
module rt_operand_loader #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_WORDS  = 16
) (
   input logic               clk,
   input logic               rst_n,
   rt_operand_loader_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_READY = 2'd2;
   localparam logic [ADDR_WIDTH:0]   LP_FULL = (ADDR_WIDTH+1)'(NUM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] LP_TOP  = ADDR_WIDTH'(NUM_WORDS-1);
   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_overflow, r_underflow, r_rd_valid;
   logic [DATA_WIDTH-1:0] r_n0p, r_rd_r, r_rd_t;
   logic [DATA_WIDTH-1:0] r_mem_r [NUM_WORDS];
   logic [DATA_WIDTH-1:0] r_mem_t [NUM_WORDS];
   logic                  w_load, w_full, w_wr, w_done, w_rd, w_rd_in;
   logic [ADDR_WIDTH:0]   w_count_nxt;
   // load_start pre-empts every other event in its cycle
   assign w_load      = r_state == S_LOAD && bus.i_word_valid && !bus.i_load_start;
   assign w_full      = r_count == LP_FULL;
   assign w_wr        = w_load && !w_full;
   // a word arriving with load_done is counted before completion is judged
   assign w_count_nxt = r_count + (ADDR_WIDTH+1)'(w_wr);
   assign w_done      = r_state == S_LOAD && bus.i_load_done && !bus.i_load_start;
   assign w_rd        = r_state == S_READY && bus.i_rd_en && !bus.i_load_start;
   assign w_rd_in     = {1'b0, bus.i_rd_addr} < LP_FULL;
   always_ff @(posedge clk) begin
      if (rst_n && w_wr) begin
         r_mem_r[r_wr_ptr] <= bus.i_r_word;
         r_mem_t[r_wr_ptr] <= bus.i_t_word;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= LP_TOP;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_n0p       <= '0;
         r_rd_r      <= '0;
         r_rd_t      <= '0;
      end else if (bus.i_load_start) begin
         r_state     <= S_LOAD;
         r_wr_ptr    <= LP_TOP;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_rd_valid  <= 1'b0;
      end else begin
         r_rd_valid <= w_rd;
         if (w_rd) begin
            r_rd_r <= w_rd_in ? r_mem_r[bus.i_rd_addr] : '0;
            r_rd_t <= w_rd_in ? r_mem_t[bus.i_rd_addr] : '0;
         end
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr - 1'b1;
            r_count  <= w_count_nxt;
         end
         if (w_load && w_full) r_overflow <= 1'b1;
         if (w_done) begin
            r_n0p       <= bus.i_n0p_in;
            r_state     <= w_count_nxt == LP_FULL ? S_READY : S_IDLE;
            r_underflow <= w_count_nxt != LP_FULL;
         end
      end
   end
   assign bus.o_r_rd_data  = r_rd_r;
   assign bus.o_t_rd_data  = r_rd_t;
   assign bus.o_rd_valid   = r_rd_valid;
   assign bus.o_n0p_out    = r_n0p;
   assign bus.o_ready      = r_state == S_READY;
   assign bus.o_busy       = r_state == S_LOAD;
   assign bus.o_word_count = r_count;
   assign bus.o_overflow   = r_overflow;
   assign bus.o_underflow  = r_underflow;
endmodule
